rgbi_hdmi_encoder: RTL

Parametrised RGBI-to-HDMI-transmitter pixel port: converts the 4-bit CGA/MDA RGBI pixel stream into COLOR_W-bit-per-channel parallel RGB with aligned sync and data-enable, ready for the external HDMI serialiser. It sits between the CRTC/attribute pipeline and the transmitter pins. Adds palette expansion, frame-synchronous mode switching, sync polarity normalisation and a programmable DE alignment delay.

---
 rtl/rgbi_hdmi_pkg.sv | 32 +++
 rtl/rgbi_hdmi_encoder_palette.sv | 42 ++++
 rtl/rgbi_hdmi_encoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rgbi_hdmi_pkg.sv
// Shared types and constants for the RGBI-to-HDMI pixel port.
// Optional scanline dimming is enabled by RGBI_HDMI_SCANLINE_EN.
package rgbi_hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_CGA       = 2'b00,
    MODE_MDA_GREEN = 2'b01,
    MODE_MDA_GREY  = 2'b10
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  localparam logic [7:0] LVL_00 = 8'h00;
  localparam logic [7:0] LVL_55 = 8'h55;
  localparam logic [7:0] LVL_AA = 8'hAA;
  localparam logic [7:0] LVL_FF = 8'hFF;

  localparam logic [3:0] BROWN_IDX = 4'h6;

  function automatic mode_e decode_mode(input logic [1:0] sel);
    unique case (sel)
      2'b01:   return MODE_MDA_GREEN;
      2'b10:   return MODE_MDA_GREY;
      default: return MODE_CGA;
    endcase
  endfunction

endpackage

// File: rtl/rgbi_hdmi_encoder_palette.sv
// Combinational RGBI palette: mode + 4-bit index to three 8-bit levels.
// Used ahead of the stage-2 register in rgbi_hdmi_encoder.
module rgbi_palette
  import rgbi_hdmi_pkg::*;
(
  input  mode_e      mode_i,
  input  logic [3:0] idx_i,
  output rgb8_t      rgb_o
);

  logic [7:0] mda;
  logic [7:0] ilvl;

  always_comb begin
    mda = LVL_00;
    if (idx_i[2:0] != 3'b000) begin
      mda = idx_i[3] ? LVL_FF : LVL_AA;
    end else if (idx_i[3]) begin
      mda = LVL_55;
    end
    // AA and 55 share no bits, so OR is the sum
    ilvl = idx_i[3] ? LVL_55 : LVL_00;
    rgb_o = '0;
    unique case (mode_i)
      MODE_MDA_GREEN: begin
        rgb_o.g = mda;
      end
      MODE_MDA_GREY: begin
        rgb_o.r = mda;
        rgb_o.g = mda;
        rgb_o.b = mda;
      end
      default: begin
        rgb_o.r = (idx_i[2] ? LVL_AA : LVL_00) | ilvl;
        rgb_o.g = (idx_i[1] ? LVL_AA : LVL_00) | ilvl;
        rgb_o.b = (idx_i[0] ? LVL_AA : LVL_00) | ilvl;
        if (idx_i == BROWN_IDX) rgb_o.g = LVL_55;
      end
    endcase
  end

endmodule

// File: rtl/rgbi_hdmi_encoder.sv
// RGBI pixel stream to parallel RGB + sync/DE for an HDMI transmitter.
// Define RGBI_HDMI_SCANLINE_EN to halve brightness on odd scanlines.
module rgbi_hdmi_encoder
  import rgbi_hdmi_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int DE_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         video_i,
  input  logic               display_enable_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [1:0]         mode_sel_i,
  input  logic [1:0]         sync_inv_i,
  output logic [COLOR_W-1:0] hdmi_r_o,
  output logic [COLOR_W-1:0] hdmi_g_o,
  output logic [COLOR_W-1:0] hdmi_b_o,
  output logic               hdmi_hs_o,
  output logic               hdmi_vs_o,
  output logic               hdmi_de_o,
  output logic               hdmi_clk_o,
  output logic               frame_start_o
);

  localparam int DE_LEN = 2 + DE_DELAY;

  logic [3:0]        video_q;
  logic              hs_q;
  logic              vs_q;
  logic              fs_q;
  mode_e             mode_q;
  logic [DE_LEN-1:0] de_line_q;
  logic              hs2_q;
  logic              vs2_q;
  rgb8_t             rgb_q;
  rgb8_t             rgb_d;
  rgb8_t             pal_rgb;
  logic              vs_rise;
  logic              hs_rise;
  logic              de_tail;

  assign vs_rise = vsync_i & ~vs_q;
  assign hs_rise = hsync_i & ~hs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_q   <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      fs_q      <= 1'b0;
      mode_q    <= MODE_CGA;
      de_line_q <= '0;
    end else begin
      video_q   <= video_i;
      hs_q      <= hsync_i;
      vs_q      <= vsync_i;
      fs_q      <= vs_rise;
      de_line_q <= {de_line_q[DE_LEN-2:0], display_enable_i};
      if (vs_rise) mode_q <= decode_mode(mode_sel_i);
    end
  end

  rgbi_palette u_palette (
    .mode_i (mode_q),
    .idx_i  (video_q),
    .rgb_o  (pal_rgb)
  );

`ifdef RGBI_HDMI_SCANLINE_EN
  logic line_q;

  // vsync wins over a coincident hsync edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b0;
    end else if (vs_rise) begin
      line_q <= 1'b0;
    end else if (hs_rise) begin
      line_q <= ~line_q;
    end
  end

  always_comb begin
    rgb_d = pal_rgb;
    if (line_q) begin
      rgb_d.r = pal_rgb.r >> 1;
      rgb_d.g = pal_rgb.g >> 1;
      rgb_d.b = pal_rgb.b >> 1;
    end
  end
`else
  logic unused_hs_rise;
  assign unused_hs_rise = hs_rise;
  assign rgb_d = pal_rgb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs_q;
      vs2_q <= vs_q;
    end
  end

  assign de_tail       = de_line_q[DE_LEN-1];
  assign hdmi_r_o      = de_tail ? rgb_q.r[7 -: COLOR_W] : '0;
  assign hdmi_g_o      = de_tail ? rgb_q.g[7 -: COLOR_W] : '0;
  assign hdmi_b_o      = de_tail ? rgb_q.b[7 -: COLOR_W] : '0;
  assign hdmi_de_o     = de_tail;
  assign hdmi_hs_o     = hs2_q ^ sync_inv_i[0];
  assign hdmi_vs_o     = vs2_q ^ sync_inv_i[1];
  assign hdmi_clk_o    = clk;
  assign frame_start_o = fs_q;

endmodule
